// File: rtl/pri_frame_monitor.sv
// pri_frame_monitor: measures PRI pulse widths/counts between SOF and EOF.
// Optional rise-to-rise period check enabled by defining PRI_PERIOD_CHK_EN.
module pri_frame_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_ON     = 2048,
    parameter int EXP_PERIOD = 6145,
    parameter int TOL        = 2,
    parameter int EXP_PULSES = 50,
    parameter int TIMEOUT    = 400000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pri,
    input  logic             sof,
    input  logic             eof,
    output logic             frame_done,
    output logic [7:0]       pulse_cnt,
    output logic [CNT_W-1:0] min_on,
    output logic [CNT_W-1:0] max_on,
    output logic             err_width,
    output logic             err_count,
    output logic             err_timeout,
    output logic             err_period
);

    localparam int FRM_W = $clog2(TIMEOUT + 1);
    localparam int ON_LO_I = (EXP_ON > TOL) ? (EXP_ON - TOL) : 0;
    localparam int ON_HI_I = EXP_ON + TOL;
    localparam logic [CNT_W:0] ON_LO = (CNT_W+1)'(ON_LO_I);
    localparam logic [CNT_W:0] ON_HI = (CNT_W+1)'(ON_HI_I);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(TIMEOUT - 1);
    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FRAME,
        S_DONE
    } state_t;

    state_t r_state;

    logic r_pri_q, r_pri_d;
    logic r_sof_q, r_sof_d;
    logic r_eof_q, r_eof_d;

    logic [7:0]       r_pcnt;
    logic [CNT_W-1:0] r_on;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_in_pulse;
    logic             r_have_w;
    logic             r_err_w;
    logic             r_tmo;

    logic w_pri_rise, w_pri_fall;
    logic w_sof_rise, w_sof_fall;
    logic w_eof_rise;
    logic w_on_bad;
    logic w_trunc;
    logic w_clear;

    assign w_pri_rise = r_pri_q & ~r_pri_d;
    assign w_pri_fall = ~r_pri_q & r_pri_d;
    assign w_sof_rise = r_sof_q & ~r_sof_d;
    assign w_sof_fall = ~r_sof_q & r_sof_d;
    assign w_eof_rise = r_eof_q & ~r_eof_d;

    assign w_on_bad = ({1'b0, r_on} < ON_LO) | ({1'b0, r_on} > ON_HI);
    // pulse still in progress when the frame closes
    assign w_trunc  = w_pri_rise | (r_in_pulse & r_pri_q);
    assign w_clear  = w_sof_rise & ((r_state == S_IDLE) | (r_state == S_FRAME));

    // register the strobes and keep one extra delay for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pri_q <= 1'b0;
            r_pri_d <= 1'b0;
            r_sof_q <= 1'b0;
            r_sof_d <= 1'b0;
            r_eof_q <= 1'b0;
            r_eof_d <= 1'b0;
        end else begin
            r_pri_q <= pri;
            r_pri_d <= r_pri_q;
            r_sof_q <= sof;
            r_sof_d <= r_sof_q;
            r_eof_q <= eof;
            r_eof_d <= r_eof_q;
        end
    end

    // frame FSM, measurement datapath and registered summary outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pcnt      <= '0;
            r_on        <= '0;
            r_min       <= CNT_MAX;
            r_max       <= '0;
            r_frm_cnt   <= '0;
            r_in_pulse  <= 1'b0;
            r_have_w    <= 1'b0;
            r_err_w     <= 1'b0;
            r_tmo       <= 1'b0;
            frame_done  <= 1'b0;
            pulse_cnt   <= '0;
            min_on      <= '0;
            max_on      <= '0;
            err_width   <= 1'b0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_clear) begin
                r_pcnt     <= '0;
                r_on       <= '0;
                r_min      <= CNT_MAX;
                r_max      <= '0;
                r_frm_cnt  <= '0;
                r_in_pulse <= 1'b0;
                r_have_w   <= 1'b0;
                r_err_w    <= 1'b0;
                r_tmo      <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_sof_rise)
                        r_state <= S_ARM;
                end
                S_ARM: begin
                    if (w_sof_fall) begin
                        r_frm_cnt <= '0;
                        r_state   <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (w_sof_rise) begin
                        r_state <= S_ARM;
                    end else begin
                        r_frm_cnt <= r_frm_cnt + FRM_ONE;
                        if (w_pri_rise) begin
                            if (r_pcnt != 8'hFF)
                                r_pcnt <= r_pcnt + 8'd1;
                            r_on       <= CNT_ONE;
                            r_in_pulse <= 1'b1;
                        end else if (r_in_pulse && r_pri_q) begin
                            if (r_on != CNT_MAX)
                                r_on <= r_on + CNT_ONE;
                        end else if (r_in_pulse && w_pri_fall) begin
                            r_in_pulse <= 1'b0;
                            r_have_w   <= 1'b1;
                            if (w_on_bad)
                                r_err_w <= 1'b1;
                            if (r_on < r_min)
                                r_min <= r_on;
                            if (r_on > r_max)
                                r_max <= r_on;
                        end
                        if (w_eof_rise || (r_frm_cnt == FRM_LAST)) begin
                            r_state <= S_DONE;
                            r_tmo   <= ~w_eof_rise;
                            if (w_trunc)
                                r_err_w <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    frame_done  <= 1'b1;
                    pulse_cnt   <= r_pcnt;
                    min_on      <= r_have_w ? r_min : '0;
                    max_on      <= r_have_w ? r_max : '0;
                    err_width   <= r_err_w;
                    err_count   <= (int'(r_pcnt) != EXP_PULSES);
                    err_timeout <= r_tmo;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PRI_PERIOD_CHK_EN
    localparam int PER_LO_I = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam int PER_HI_I = EXP_PERIOD + TOL;
    localparam logic [CNT_W:0] PER_LO = (CNT_W+1)'(PER_LO_I);
    localparam logic [CNT_W:0] PER_HI = (CNT_W+1)'(PER_HI_I);

    logic [CNT_W-1:0] r_per;
    logic             r_per_run;
    logic             r_err_p;
    logic             w_per_bad;

    // a saturated period counter is always treated as out of range
    assign w_per_bad = ({1'b0, r_per} < PER_LO) | ({1'b0, r_per} > PER_HI) |
                       (r_per == CNT_MAX);

    // rise-to-rise period measurement; first rise of a frame only starts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_per      <= '0;
            r_per_run  <= 1'b0;
            r_err_p    <= 1'b0;
            err_period <= 1'b0;
        end else begin
            if (w_clear) begin
                r_per     <= '0;
                r_per_run <= 1'b0;
                r_err_p   <= 1'b0;
            end else if (r_state == S_FRAME) begin
                if (w_pri_rise) begin
                    r_per     <= CNT_ONE;
                    r_per_run <= 1'b1;
                    if (r_per_run && w_per_bad)
                        r_err_p <= 1'b1;
                end else if (r_per_run && (r_per != CNT_MAX)) begin
                    r_per <= r_per + CNT_ONE;
                end
            end
            if (r_state == S_DONE)
                err_period <= r_err_p;
        end
    end
`else
    assign err_period = 1'b0;
`endif

endmodule

// File: tb/tb_pri_frame_monitor.sv
// Directed bench for pri_frame_monitor with scaled-down timing parameters.
// Nominal pulse: 20 cycles high, 61-cycle period, 5 pulses per frame.
module tb_pri_frame_monitor;

    localparam int CNT_W   = 16;
    localparam int ON      = 20;
    localparam int PER     = 61;
    localparam int NP      = 5;
    localparam int TMO     = 1000;

    logic             clk;
    logic             reset_n;
    logic             pri;
    logic             sof;
    logic             eof;
    logic             frame_done;
    logic [7:0]       pulse_cnt;
    logic [CNT_W-1:0] min_on;
    logic [CNT_W-1:0] max_on;
    logic             err_width;
    logic             err_count;
    logic             err_timeout;
    logic             err_period;

    int n_tot;
    int n_pass;
    int n_done;
    int cyc;

    pri_frame_monitor #(
        .CNT_W(CNT_W),
        .EXP_ON(ON),
        .EXP_PERIOD(PER),
        .TOL(2),
        .EXP_PULSES(NP),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pri(pri),
        .sof(sof),
        .eof(eof),
        .frame_done(frame_done),
        .pulse_cnt(pulse_cnt),
        .min_on(min_on),
        .max_on(max_on),
        .err_width(err_width),
        .err_count(err_count),
        .err_timeout(err_timeout),
        .err_period(err_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done)
            n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            chk("done_seen", 0, 1);
    endtask

    task automatic sof_pulse();
        sof = 1'b1;
        tick(10);
        sof = 1'b0;
        tick(5);
    endtask

    // drive np pulses; one pulse may get a different width, one a longer gap
    task automatic pulses(input int np, input int w_idx, input int w_on,
                          input int g_idx, input int g_extra,
                          input bit trunc_last);
        int on;
        int off;
        for (int i = 0; i < np; i++) begin
            on  = (i == w_idx) ? w_on : ON;
            off = PER - on + ((i == g_idx) ? g_extra : 0);
            pri = 1'b1;
            tick(on);
            if (trunc_last && (i == np - 1))
                break;
            pri = 1'b0;
            tick(off);
        end
    endtask

    task automatic frame(input int np, input int w_idx, input int w_on,
                         input int g_idx, input int g_extra,
                         input bit trunc_last, output bit seen);
        sof_pulse();
        pulses(np, w_idx, w_on, g_idx, g_extra, trunc_last);
        eof = 1'b1;
        wait_done(seen);
        eof = 1'b0;
        pri = 1'b0;
        tick(3);
    endtask

    task automatic check_summary(input string tag, input int pc,
                                 input int mn, input int mx,
                                 input bit ew, input bit ec, input bit et);
        chk({tag, "_pulse_cnt"}, pulse_cnt, pc);
        chk({tag, "_min_on"}, min_on, mn);
        chk({tag, "_max_on"}, max_on, mx);
        chk({tag, "_err_width"}, err_width, ew);
        chk({tag, "_err_count"}, err_count, ec);
        chk({tag, "_err_timeout"}, err_timeout, et);
    endtask

    initial begin
        bit seen;
        int t0;
        int d0;
        int lat;
        n_tot   = 0;
        n_pass  = 0;
        n_done  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        pri     = 1'b0;
        sof     = 1'b0;
        eof     = 1'b0;
        tick(3);

        chk("rst_frame_done", frame_done, 0);
        check_summary("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_err_period", err_period, 0);
        reset_n = 1'b1;
        tick(3);

        // nominal frame
        d0 = n_done;
        frame(NP, -1, 0, -1, 0, 1'b0, seen);
        if (seen) begin
            check_summary("nom", 5, 20, 20, 0, 0, 0);
            chk("nom_err_period", err_period, 0);
        end
        chk("nom_done_once", n_done - d0, 1);

        // one wide pulse
        frame(NP, 2, 32, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("wide", 5, 20, 32, 1, 0, 0);

        // upper tolerance edge is still good
        frame(NP, 1, 22, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("tol_hi", 5, 20, 22, 0, 0, 0);

        // just below lower tolerance
        frame(NP, 3, 17, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("narrow", 5, 17, 20, 1, 0, 0);

        // one pulse short of expected count
        frame(NP - 1, -1, 0, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("cnt", 4, 20, 20, 0, 1, 0);

        // eof while last pulse is still high
        frame(NP, -1, 0, -1, 0, 1'b1, seen);
        if (seen)
            check_summary("trunc", 5, 20, 20, 1, 0, 0);

        // empty frame
        frame(0, -1, 0, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("empty", 0, 0, 0, 0, 1, 0);

        // one long gap between pulses 3 and 4 (period 70)
        frame(NP, -1, 0, 2, 9, 1'b0, seen);
        if (seen) begin
            check_summary("per", 5, 20, 20, 0, 0, 0);
`ifdef PRI_PERIOD_CHK_EN
            chk("per_err_period", err_period, 1);
`else
            chk("per_err_period", err_period, 0);
`endif
        end

        // timeout: three pulses, no eof
        sof = 1'b1;
        tick(10);
        sof = 1'b0;
        t0 = cyc;
        tick(5);
        pulses(3, -1, 0, -1, 0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        lat = cyc - t0;
        chk("tmo_done_seen", seen, 1);
        if (seen) begin
            chk("tmo_latency", lat, 1003);
            check_summary("tmo", 3, 20, 20, 0, 1, 1);
        end
        tick(3);

        // resync: sof again after two pulses, then a full nominal frame
        d0 = n_done;
        sof_pulse();
        pulses(2, -1, 0, -1, 0, 1'b0);
        frame(NP, -1, 0, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("resync", 5, 20, 20, 0, 0, 0);
        chk("resync_done_once", n_done - d0, 1);

        // reset mid-frame clears outputs and suppresses frame_done
        d0 = n_done;
        sof_pulse();
        pulses(2, -1, 0, -1, 0, 1'b0);
        pri = 1'b1;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        check_summary("midrst", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick(10);
        pri = 1'b0;
        tick(5);
        eof = 1'b1;
        tick(10);
        eof = 1'b0;
        tick(5);
        chk("midrst_no_done", n_done - d0, 0);

        // recovery after reset
        frame(NP, -1, 0, -1, 0, 1'b0, seen);
        if (seen)
            check_summary("recover", 5, 20, 20, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
